// File: rtl/psum_accum_buffer.sv
// Accumulates per-channel partial sums into an OFM-sized buffer and streams finished pixels on the last pass.
// Optional feature: define PSUM_SAT_EN to clamp overflowing sums (default build wraps).
module psum_accum_buffer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned OFM_WIDTH   = 62,
  parameter int unsigned OFM_HEIGHT  = 62,
  parameter int unsigned NUM_CHANNEL = 3
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [DATA_WIDTH-1:0] psum_data,
  output logic                  ofm_valid,
  input  logic                  ofm_ready,
  output logic [ACC_WIDTH-1:0]  ofm_data,
  output logic [4:0]            cnt_channel,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned DEPTH = OFM_WIDTH * OFM_HEIGHT;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = ACC_WIDTH + 1;
  localparam logic [AW-1:0] LAST_ADDR     = AW'(DEPTH - 1);
  localparam logic [4:0]    LAST_ACCUM_CH = 5'(NUM_CHANNEL - 2);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LAST, S_FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   ofm_valid_q, ofm_valid_d;
  logic [ACC_WIDTH-1:0]   ofm_data_q, ofm_data_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;

  logic [ACC_WIDTH-1:0]   mem [DEPTH];
  logic [ACC_WIDTH-1:0]   base_c, psum_ext_c, acc_c;
  logic [SW-1:0]          sum_c;
  logic                   ovf_c, accept_c, mem_we_c;

  // Channel 0 (and single-channel maps) start from zero instead of the stale buffer word.
  assign psum_ext_c = ACC_WIDTH'($signed(psum_data));
  assign base_c     = (cnt_q == 5'd0) ? '0 : mem[addr_q];
  assign sum_c      = {base_c[ACC_WIDTH-1], base_c} + {psum_ext_c[ACC_WIDTH-1], psum_ext_c};
  assign ovf_c      = sum_c[SW-1] ^ sum_c[SW-2];

`ifdef PSUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign acc_c = !ovf_c ? sum_c[ACC_WIDTH-1:0] : (sum_c[SW-1] ? ACC_MIN : ACC_MAX);
`else
  assign acc_c = sum_c[ACC_WIDTH-1:0];
`endif

  always_comb begin
    psum_ready = 1'b0;
    if (!start) begin
      unique case (state_q)
        S_ACCUM: psum_ready = 1'b1;
        S_LAST:  psum_ready = !ofm_valid_q || ofm_ready;
        default: psum_ready = 1'b0;
      endcase
    end
  end

  assign accept_c = psum_valid && psum_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ofm_valid_d = ofm_valid_q;
    ofm_data_d  = ofm_data_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    mem_we_c    = 1'b0;
    if (start) begin
      state_d     = (NUM_CHANNEL > 1) ? S_ACCUM : S_LAST;
      addr_d      = '0;
      cnt_d       = '0;
      ofm_valid_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ACCUM: begin
          if (accept_c) begin
            mem_we_c   = 1'b1;
            overflow_d = overflow_q | ovf_c;
            if (addr_q == LAST_ADDR) begin
              addr_d = '0;
              cnt_d  = cnt_q + 5'd1;
              if (cnt_q == LAST_ACCUM_CH) state_d = S_LAST;
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end
        end
        S_LAST: begin
          if (ofm_ready) ofm_valid_d = 1'b0;
          if (accept_c) begin
            ofm_valid_d = 1'b1;
            ofm_data_d  = acc_c;
            overflow_d  = overflow_q | ovf_c;
            if (addr_q == LAST_ADDR) begin
              addr_d  = '0;
              cnt_d   = cnt_q + 5'd1;
              state_d = S_FLUSH;
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (ofm_valid_q && ofm_ready) begin
            ofm_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      ofm_valid_q <= 1'b0;
      ofm_data_q  <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ofm_valid_q <= ofm_valid_d;
      ofm_data_q  <= ofm_data_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Buffer has no reset; channel 0 overwrites every word before it is read back.
  always_ff @(posedge clk1) begin
    if (mem_we_c) mem[addr_q] <= acc_c;
  end

  assign ofm_valid   = ofm_valid_q;
  assign ofm_data    = ofm_data_q;
  assign cnt_channel = cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign overflow    = overflow_q;

endmodule
